// File: rtl/layer_compositor.sv
// N-layer priority compositor with colour-key transparency, frame-synced enables, overlap flags and fade.
// Latency 2 pixel_ticks to o_rgb/o_hit_*; no backpressure, pipeline advances only on i_pixel_tick.
module layer_compositor #(
  parameter int          N_LAYERS    = 4,
  parameter int          RGB_W       = 12,
  parameter logic [11:0] KEY_RGB     = 12'hF0F,
  parameter logic [11:0] BG_RGB      = 12'h000,
  parameter int          FADE_FRAMES = 4,
  localparam int         IDX_W       = $clog2(N_LAYERS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_pixel_tick,
  input  logic                      i_video_on,
  input  logic                      i_frame_start,
  input  logic [N_LAYERS*RGB_W-1:0] i_layer_rgb,
  input  logic [N_LAYERS-1:0]       i_layer_on,
  input  logic [N_LAYERS-1:0]       i_layer_en_next,
  input  logic                      i_fade_req,
  input  logic                      i_fade_dir,
  output logic [RGB_W-1:0]          o_rgb,
  output logic [IDX_W-1:0]          o_hit_idx,
  output logic                      o_hit_valid,
  output logic [N_LAYERS-1:0]       o_overlap,
  output logic                      o_fade_busy,
  output logic [3:0]                o_fade_level
);

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_IN} state_t;

  localparam logic [7:0]          LP_FF_LAST = 8'(FADE_FRAMES - 1);
  localparam logic [N_LAYERS-1:0] LP_ONE     = N_LAYERS'(1);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_lvl, w_lvl_nxt;
  logic [7:0]            r_fcnt, w_fcnt_nxt;
  logic [N_LAYERS-1:0]   r_en_q, r_ov_acc, r_overlap;
  logic [RGB_W-1:0]      r_s1_rgb, r_rgb;
  logic [IDX_W-1:0]      r_s1_idx, r_idx;
  logic                  r_s1_hit, r_s1_von, r_hit;

  logic [N_LAYERS-1:0]   w_opq, w_contrib;
  logic                  w_multi, w_fs, w_sel_hit;
  logic [RGB_W-1:0]      w_sel_rgb;
  logic [IDX_W-1:0]      w_sel_idx;

  // Per 4-bit channel: (c * (lvl+1)) >> 4 on an 8-bit product.
  function automatic logic [11:0] f_fade(input logic [11:0] c, input logic [3:0] lvl);
    logic [11:0] res;
    logic [7:0]  p;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      p = {4'd0, c[4*ch +: 4]} * ({4'd0, lvl} + 8'd1);
      res[4*ch +: 4] = p[7:4];
    end
    return res;
  endfunction

  assign w_fs = i_pixel_tick && i_frame_start;

  always_comb begin
    w_opq     = '0;
    w_sel_rgb = BG_RGB;
    w_sel_idx = '0;
    w_sel_hit = 1'b0;
    for (int i = 0; i < N_LAYERS; i++)
      w_opq[i] = i_layer_on[i] && r_en_q[i] && (i_layer_rgb[RGB_W*i +: RGB_W] != KEY_RGB);
    // Walk from lowest priority up so the lowest opaque index is the last writer.
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (w_opq[i]) begin
        w_sel_rgb = i_layer_rgb[RGB_W*i +: RGB_W];
        w_sel_idx = IDX_W'(i);
        w_sel_hit = 1'b1;
      end
    end
  end

  assign w_multi   = |(w_opq & (w_opq - LP_ONE));
  assign w_contrib = (w_multi && i_video_on) ? w_opq : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;
    w_fcnt_nxt  = r_fcnt;
    if (i_fade_req) begin
      w_state_nxt = i_fade_dir ? S_OUT : S_IN;
      w_fcnt_nxt  = '0;
    end else if (w_fs) begin
      case (r_state)
        S_OUT: begin
          if (r_lvl == 4'd0) begin
            w_state_nxt = S_IDLE;
          end else if (r_fcnt >= LP_FF_LAST) begin
            w_fcnt_nxt = '0;
            w_lvl_nxt  = r_lvl - 4'd1;
            if (r_lvl == 4'd1) w_state_nxt = S_IDLE;
          end else begin
            w_fcnt_nxt = r_fcnt + 8'd1;
          end
        end
        S_IN: begin
          if (r_lvl == 4'd15) begin
            w_state_nxt = S_IDLE;
          end else if (r_fcnt >= LP_FF_LAST) begin
            w_fcnt_nxt = '0;
            w_lvl_nxt  = r_lvl + 4'd1;
            if (r_lvl == 4'd14) w_state_nxt = S_IDLE;
          end else begin
            w_fcnt_nxt = r_fcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_lvl   <= 4'd15;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lvl   <= w_lvl_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_en_q    <= '1;
      r_ov_acc  <= '0;
      r_overlap <= '0;
      r_s1_rgb  <= '0;
      r_s1_idx  <= '0;
      r_s1_hit  <= 1'b0;
      r_s1_von  <= 1'b0;
      r_rgb     <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
    end else if (i_pixel_tick) begin
      r_s1_rgb <= w_sel_rgb;
      r_s1_idx <= w_sel_idx;
      r_s1_hit <= w_sel_hit;
      r_s1_von <= i_video_on;
      r_rgb    <= r_s1_von ? f_fade(r_s1_rgb, r_lvl) : '0;
      r_idx    <= r_s1_idx;
      r_hit    <= r_s1_hit && r_s1_von;
      if (i_frame_start) begin
        r_en_q    <= i_layer_en_next;
        r_overlap <= r_ov_acc;
        r_ov_acc  <= w_contrib;
      end else begin
        r_ov_acc  <= r_ov_acc | w_contrib;
      end
    end
  end

  assign o_rgb        = r_rgb;
  assign o_hit_idx    = r_idx;
  assign o_hit_valid  = r_hit;
  assign o_overlap    = r_overlap;
  assign o_fade_busy  = (r_state != S_IDLE);
  assign o_fade_level = r_lvl;

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised N-layer pixel compositor that generalises the top-level RGB multiplexer: priority selection across any number of sprite/tile layers, colour-key transparency, frame-synchronous layer enables, per-frame overlap (collision) flags and a frame-stepped fade-to-black/fade-in. It sits between the object/background engines and the VGA DAC, replacing the hand-written `if/else` mux and `rgb_reg` buffer in the display top.

## Interface
- `N_LAYERS`, 4: number of input layers (2..16); layer 0 is the highest priority.
- `RGB_W`, 12: pixel width, 4 bits per channel; must be 12.
- `KEY_RGB`, 12'hF0F: colour key; a layer pixel equal to it is transparent.
- `BG_RGB`, 12'h000: output colour where no layer is opaque.
- `FADE_FRAMES`, 4: frames per fade step (1..255).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pixel_tick`  in  1  pixel-rate enable from `vga_sync`; all pipeline registers advance only when it is high.
- `video_on`  in  1  active-area flag, aligned with `layer_rgb`.
- `frame_start`  in  1  one-`pixel_tick` pulse at x=0,y=0, aligned with `layer_rgb`.
- `layer_rgb`  in  N_LAYERS*12  packed layer colours; layer i is at [12i+11:12i].
- `layer_on`  in  N_LAYERS  layer i covers the current pixel.
- `layer_en_next`  in  N_LAYERS  requested layer enables, applied at the next frame boundary.
- `fade_req`  in  1  single-cycle pulse that starts a fade.
- `fade_dir`  in  1  sampled with `fade_req`: 1 = fade out to black, 0 = fade in.
- `rgb`  out  12  composited, faded pixel to the DAC.
- `hit_idx`  out  clog2(N_LAYERS)  index of the winning layer, pipeline-aligned with `rgb`.
- `hit_valid`  out  1  a layer (not `BG_RGB`) won the current `rgb` pixel.
- `overlap`  out  N_LAYERS  per-frame flags: layer i was opaque on a pixel where at least one other layer was also opaque.
- `fade_busy`  out  1  a fade is in progress.
- `fade_level`  out  4  current brightness; 15 = full, 0 = black.

## Operation
- Active enable register `en_q` loads `layer_en_next` when `pixel_tick && frame_start`. Enables never change mid-frame. Reset value is all ones.
- A layer is opaque when `layer_on[i] && en_q[i] && layer_rgb[i] != KEY_RGB`. The lowest opaque index wins. If no layer is opaque, the output is `BG_RGB` with `hit_valid`=0.
- Overlap: accumulator `ov_acc[i]` is set when layer i is opaque, at least one other layer is opaque, and `video_on` is high.
  - At `frame_start`, `overlap` <= `ov_acc`, then the accumulator clears.
  - The frame_start pixel's own overlaps count toward the new frame.
- Fade FSM, with states IDLE, OUT, IN:
  - In IDLE, `fade_req`=1 with `fade_dir`=1 goes to OUT; with `fade_dir`=0 it goes to IN.
  - Each state has a frame counter; every `FADE_FRAMES` frame_starts, OUT decrements `fade_level` and IN increments it.
  - OUT returns to IDLE when the level reaches 0. IN returns to IDLE when the level reaches 15.
  - A `fade_req` during OUT or IN reverses direction from the current level and resets the frame counter.
  - A fade requested toward the level already held returns to IDLE at the next frame_start.
  - `fade_busy` = (state != IDLE).
  - The level holds after the fade completes. Level 0 persists (black screen) until a fade-in.
- Fade arithmetic, per 4-bit channel c: out = (c * (fade_level+1)) >> 4. This uses an 8-bit product and truncates. Level 15 is identity; level 0 gives 0.
- Blanking: when the pipelined `video_on` is low, `rgb`=0 and `hit_valid`=0, regardless of layers or fade.

## Timing
- Two-stage pipeline, advancing on `pixel_tick` only:
  - Stage 1 registers the selected colour, `hit_idx`, `hit_valid` and `video_on`.
  - Stage 2 applies fade and blanking and drives `rgb`.
- Latency is 2 `pixel_tick`s from inputs to `rgb`/`hit_idx`/`hit_valid`. The display top must delay `hsync`/`vsync` by 2 ticks.
- `overlap`, `en_q` and `fade_level` update on the same clock edge as the qualifying frame_start tick.
  - A frame_start that coincides with a `fade_req` applies the request first; the first step occurs `FADE_FRAMES` frames later.
- Reset values:
  - `rgb`=0, `hit_idx`=0, `hit_valid`=0, `overlap`=0, `fade_busy`=0, `fade_level`=15.
  - State IDLE; accumulator and pipeline cleared.
- Reset asserted mid-frame or mid-fade takes effect immediately. It does not wait for a frame boundary.

## Test plan
- Priority: N=4, all enabled, layers 1 and 3 on with 12'h0F0 and 12'h00F. After 2 ticks, `rgb`=12'h0F0, `hit_idx`=1, `hit_valid`=1.
- Transparency: layer 0 on with 12'hF0F, layer 2 on with 12'h123. `rgb`=12'h123, `hit_idx`=2. With no layer on, `rgb`=12'h000, `hit_valid`=0.
- Frame-sync enables: mid-frame `layer_en_next`=4'b1110 with layer 0 at 12'hFFF. Layer 0 still wins until the next frame_start, and is then ignored.
- Overlap: in frame k, layers 0 and 2 are opaque on one pixel. After frame_start k+1, `overlap`=4'b0101. After frame_start k+2 with no overlap, it is 4'b0000.
- Fade: with `FADE_FRAMES`=1 and a constant 12'hFFF pixel, pulse `fade_req`/`fade_dir`=1.
  - The level steps 15→0 over 15 frames, and `rgb` goes 12'hFFF, 12'hEEE … 12'h000.
  - `fade_busy` drops with level 0.
  - A reversal request at level 8 climbs back to 15.
- Blanking/reset: with `video_on`=0, `rgb`=0 under any layer data. Asserting `reset` mid-fade gives `fade_level`=15, `fade_busy`=0 and `rgb`=0 asynchronously.
